// File: rtl/wrdm_desc_arbiter.sv
// ---------------------------------------------------------------------------
// WrdmDescArbiter (module wrdm_desc_arbiter)
//
// Purpose: round-robin arbiter that merges descriptor streams from NUM_REQ
// requesters into the single descriptor port of the write data mover. Once
// a requester wins, the port is locked to it until it delivers a descriptor
// flagged with req_last, so bursts never interleave. The output side is a
// single registered stage (valid/data) with standard ready/valid backpressure.
//
// Ports:
//   clk              sole clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   req_valid[N]     per-requester descriptor valid
//   req_data[N*W]    flattened descriptors, requester i at [i*W +: W]
//   req_last[N]      final descriptor of a requester's burst
//   req_ready[N]     per-requester accept
//   wrdm_desc_valid  descriptor valid towards the write data mover
//   wrdm_desc_data   descriptor towards the write data mover
//   wrdm_desc_ready  write data mover accepts the current descriptor
//   grant_id         requester currently owning the port
//   grant_active     high while a burst is locked
//   burst_cnt        (only with WRDM_ARB_STATS_EN) per-requester 32-bit
//                    wrapping count of completed bursts
//
// Optional feature macro: WRDM_ARB_STATS_EN
// ---------------------------------------------------------------------------
module wrdm_desc_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DESC_WIDTH = 174,
   localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DESC_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          wrdm_desc_valid,
   output logic [DESC_WIDTH-1:0]         wrdm_desc_data,
   input  logic                          wrdm_desc_ready,
   output logic [GW-1:0]                 grant_id,
`ifdef WRDM_ARB_STATS_EN
   output logic [NUM_REQ*32-1:0]         burst_cnt,
`endif
   output logic                          grant_active
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           grant_id_q, grant_id_d;
   logic [GW-1:0]           last_grant_q, last_grant_d;
   logic                    grant_active_q, grant_active_d;
   logic                    out_valid_q, out_valid_d;
   logic [DESC_WIDTH-1:0]   out_data_q, out_data_d;

   logic [GW-1:0]           winner;
   logic                    winner_found;
   logic [GW-1:0]           cand;
   logic [DESC_WIDTH-1:0]   grant_data;
   logic                    accept;
   logic                    accept_last;

   // Round-robin search: start one past the previous burst owner and take
   // the first requester with a valid descriptor.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      cand         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
         if (!winner_found && req_valid[cand]) begin
            winner       = cand;
            winner_found = 1'b1;
         end
      end
   end

   assign grant_data  = req_data[int'(grant_id_q)*DESC_WIDTH +: DESC_WIDTH];
   assign accept      = req_valid[grant_id_q] & req_ready[grant_id_q];
   assign accept_last = accept & req_last[grant_id_q];

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         grant_id_q     <= '0;
         last_grant_q   <= GW'(NUM_REQ - 1);
         grant_active_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         grant_id_q     <= grant_id_d;
         last_grant_q   <= last_grant_d;
         grant_active_q <= grant_active_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
      end
   end

   // Next-state logic. The output stage is updated independently of the
   // state so the final descriptor of a burst can still be draining during
   // the single IDLE cycle spent re-arbitrating.
   always_comb begin
      state_d        = state_q;
      grant_id_d     = grant_id_q;
      last_grant_d   = last_grant_q;
      grant_active_d = grant_active_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;

      case (state_q)
         IDLE: begin
            if (winner_found) begin
               grant_id_d     = winner;
               grant_active_d = 1'b1;
               state_d        = LOCKED;
            end
         end
         LOCKED: begin
            if (accept_last) begin
               last_grant_d   = grant_id_q;
               grant_active_d = 1'b0;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
      end else if (wrdm_desc_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Outputs. Only the grantee sees ready, and only when the output stage
   // is empty or being drained this cycle.
   always_comb begin
      req_ready = '0;
      if (state_q == LOCKED) begin
         req_ready[grant_id_q] = ~out_valid_q | wrdm_desc_ready;
      end
   end

   assign wrdm_desc_valid = out_valid_q;
   assign wrdm_desc_data  = out_data_q;
   assign grant_id        = grant_id_q;
   assign grant_active    = grant_active_q;

`ifdef WRDM_ARB_STATS_EN
   logic [NUM_REQ*32-1:0] burst_cnt_q, burst_cnt_d;

   // Completed-burst counters, bumped on every accepted last descriptor.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (accept_last) begin
         burst_cnt_d[int'(grant_id_q)*32 +: 32] =
            burst_cnt_q[int'(grant_id_q)*32 +: 32] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign burst_cnt = burst_cnt_q;
`else
   // Default build: no statistics counters.
`endif

endmodule

// File: tb/tb_wrdm_desc_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for wrdm_desc_arbiter (NUM_REQ=4, DESC_WIDTH=174).
// Cycle-exact vector table for reset, single-beat latency and backpressure,
// followed by model-driven sequences for fairness, mid-burst arrivals,
// grantee stalls and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_wrdm_desc_arbiter;

   localparam int N = 4;
   localparam int W = 174;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic             wrdm_desc_valid;
   logic [W-1:0]     wrdm_desc_data;
   logic             wrdm_desc_ready;
   logic [1:0]       grant_id;
   logic             grant_active;
`ifdef WRDM_ARB_STATS_EN
   logic [N*32-1:0]  burst_cnt;
`endif

   wrdm_desc_arbiter #(.NUM_REQ(N), .DESC_WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .wrdm_desc_valid (wrdm_desc_valid),
      .wrdm_desc_data  (wrdm_desc_data),
      .wrdm_desc_ready (wrdm_desc_ready),
      .grant_id        (grant_id),
`ifdef WRDM_ARB_STATS_EN
      .burst_cnt       (burst_cnt),
`endif
      .grant_active    (grant_active)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   int nCompared = 0;
   int nFailed   = 0;

   // One comparison: counts it and reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        dready;
      logic [15:0] tag;
      logic [3:0]  eReady;
      logic        eValid;
      logic [15:0] eData;
      logic [1:0]  eGid;
      logic        eAct;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic r, input logic [3:0] v,
                               input logic [3:0] l, input logic d,
                               input logic [15:0] t, input logic [3:0] er,
                               input logic ev, input logic [15:0] ed,
                               input logic [1:0] eg, input logic ea);
      vec_t x;
      x.rst = r; x.valid = v; x.last = l; x.dready = d; x.tag = t;
      x.eReady = er; x.eValid = ev; x.eData = ed; x.eGid = eg; x.eAct = ea;
      return x;
   endfunction

   // Drives one table row; requester i presents descriptor tag+i.
   task automatic applyStimulus(input vec_t v);
      rst             = v.rst;
      req_valid       = v.valid;
      req_last        = v.last;
      wrdm_desc_ready = v.dready;
      for (int i = 0; i < N; i++) begin
         req_data[i*W +: W] = W'(v.tag) + W'(i);
      end
   endtask

   // ---------------- sequence model ----------------
   logic [3:0]     validMask;
   int             cnt[N];
   logic [W-1:0]   expQ[$];
   logic [1:0]     grantLog[$];
   logic           prevActive;
   logic [1:0]     prevGid;
   int             nOut;

   function automatic logic [W-1:0] buildDesc(input int i, input int n);
      logic [W-1:0] d;
      d           = '0;
      d[W-1 -: 8] = 8'(i + 1);
      d[100 +: 8] = 8'(n * 7 + i);
      d[15:0]     = 16'(n);
      return d;
   endfunction

   task automatic applyReset();
      rst             = 1'b1;
      req_valid       = '0;
      req_last        = '0;
      req_data        = '0;
      wrdm_desc_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b0;
      validMask  = '0;
      prevActive = 1'b0;
      prevGid    = '0;
      nOut       = 0;
      expQ.delete();
      grantLog.delete();
      for (int i = 0; i < N; i++) cnt[i] = 0;
   endtask

   // Runs n cycles with every requester in validMask streaming 3-beat
   // bursts; a scoreboard checks output order/content and lock ownership.
   task automatic runCycles(input int n);
      logic [3:0] acc;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = buildDesc(i, cnt[i]);
            req_last[i]        = (cnt[i] % 3 == 2);
         end
         req_valid       = validMask;
         wrdm_desc_ready = 1'b1;
         @(negedge clk);
         if (wrdm_desc_valid) begin
            nOut++;
            if (expQ.size() == 0)
               checkOutput("out_unexpected", 256'(wrdm_desc_data), 256'(0) - 1);
            else
               checkOutput("out_data", 256'(wrdm_desc_data), 256'(expQ.pop_front()));
         end
         if (grant_active && !prevActive) grantLog.push_back(grant_id);
         if (grant_active && prevActive)
            checkOutput("grant_hold", 256'(grant_id), 256'(prevGid));
         acc = req_valid & req_ready;
         if (acc != 4'b0000)
            checkOutput("accept_owner", 256'({grant_active, acc}),
                        256'({1'b1, 4'(4'b0001 << prevGidOrCur(grant_id))}));
         for (int i = 0; i < N; i++)
            if (acc[i]) expQ.push_back(buildDesc(i, cnt[i]));
         prevActive = grant_active;
         prevGid    = grant_id;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (acc[i]) cnt[i]++;
      end
   endtask

   function automatic int prevGidOrCur(input logic [1:0] g);
      return int'(g);
   endfunction

   task automatic checkGrantLog(input string name, input logic [1:0] exp[$]);
      checkOutput({name, "_count"}, 256'(grantLog.size() >= exp.size()), 256'(1));
      for (int i = 0; i < exp.size(); i++)
         if (i < grantLog.size())
            checkOutput($sformatf("%s_%0d", name, i), 256'(grantLog[i]), 256'(exp[i]));
   endtask

   initial begin
      logic [1:0] expLog[$];

      // Reset, single-beat latency, then a 2-beat burst under 5 stall cycles.
      vecs[0]  = mk(1, 4'b0000, 4'b0000, 1, 16'h00, 4'b0000, 0, 16'h00, 0, 0);
      vecs[1]  = mk(0, 4'b0100, 4'b0100, 1, 16'h58, 4'b0000, 0, 16'h00, 0, 0);
      vecs[2]  = mk(0, 4'b0100, 4'b0100, 1, 16'h58, 4'b0100, 0, 16'h00, 2, 1);
      vecs[3]  = mk(0, 4'b0000, 4'b0000, 1, 16'h58, 4'b0000, 1, 16'h5A, 2, 0);
      vecs[4]  = mk(0, 4'b0000, 4'b0000, 1, 16'h58, 4'b0000, 0, 16'h5A, 2, 0);
      vecs[5]  = mk(0, 4'b1000, 4'b0000, 0, 16'h10, 4'b0000, 0, 16'h5A, 2, 0);
      vecs[6]  = mk(0, 4'b1000, 4'b0000, 0, 16'h10, 4'b1000, 0, 16'h5A, 3, 1);
      for (int r = 7; r <= 11; r++)
         vecs[r] = mk(0, 4'b1000, 4'b0000, 0, 16'h20, 4'b0000, 1, 16'h13, 3, 1);
      vecs[12] = mk(0, 4'b1000, 4'b1000, 1, 16'h20, 4'b1000, 1, 16'h13, 3, 1);
      vecs[13] = mk(0, 4'b0000, 4'b0000, 0, 16'h20, 4'b0000, 1, 16'h23, 3, 0);
      vecs[14] = mk(0, 4'b0000, 4'b0000, 1, 16'h20, 4'b0000, 1, 16'h23, 3, 0);
      vecs[15] = mk(0, 4'b0000, 4'b0000, 1, 16'h20, 4'b0000, 0, 16'h23, 3, 0);

      applyReset();
      for (int r = 0; r < 16; r++) begin
         applyStimulus(vecs[r]);
         @(negedge clk);
         checkOutput($sformatf("v%0d_req_ready", r), 256'(req_ready), 256'(vecs[r].eReady));
         checkOutput($sformatf("v%0d_valid", r), 256'(wrdm_desc_valid), 256'(vecs[r].eValid));
         checkOutput($sformatf("v%0d_data", r), 256'(wrdm_desc_data), 256'(vecs[r].eData));
         checkOutput($sformatf("v%0d_grant_id", r), 256'(grant_id), 256'(vecs[r].eGid));
         checkOutput($sformatf("v%0d_active", r), 256'(grant_active), 256'(vecs[r].eAct));
         @(posedge clk);
         #1;
      end

      // Fairness with everyone valid: 0,1,2,3,0,1,2,3 and 24 descriptors out.
      $display("[TB] fairness sequence");
      applyReset();
      validMask = 4'b1111;
      runCycles(34);
      expLog = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      checkGrantLog("fair", expLog);
      checkOutput("fair_out_count", 256'(nOut >= 24), 256'(1));
      checkOutput("fair_queue_bound", 256'(expQ.size() <= 1), 256'(1));

      // Req1 locked, stalls with valid low, then req0/req3 arrive mid-burst.
      $display("[TB] mid-burst arrival sequence");
      applyReset();
      validMask = 4'b0001;
      runCycles(4);
      validMask = 4'b0010;
      runCycles(2);
      validMask = 4'b0000;
      runCycles(3);
      checkOutput("stall_active", 256'(grant_active), 256'(1));
      checkOutput("stall_gid", 256'(grant_id), 256'(1));
      validMask = 4'b1011;
      runCycles(9);
      expLog = '{2'd0, 2'd1, 2'd3, 2'd0};
      checkGrantLog("rr", expLog);

      // Reset while an output descriptor is pending.
      $display("[TB] reset mid-burst sequence");
      applyReset();
      validMask = 4'b1111;
      runCycles(3);
      wrdm_desc_ready = 1'b0;
      rst             = 1'b1;
      @(negedge clk);
      checkOutput("pre_rst_valid", 256'(wrdm_desc_valid), 256'(1));
      @(posedge clk);
      #1;
      checkOutput("rst_valid", 256'(wrdm_desc_valid), 256'(0));
      checkOutput("rst_data", 256'(wrdm_desc_data), 256'(0));
      checkOutput("rst_req_ready", 256'(req_ready), 256'(0));
      checkOutput("rst_gid", 256'(grant_id), 256'(0));
      checkOutput("rst_active", 256'(grant_active), 256'(0));
      rst        = 1'b0;
      prevActive = 1'b0;
      expQ.delete();
      grantLog.delete();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      runCycles(3);
      expLog = '{2'd0};
      checkGrantLog("post_rst", expLog);

`ifdef WRDM_ARB_STATS_EN
      // Ten bursts from requester 1 only.
      $display("[TB] statistics sequence");
      applyReset();
      validMask = 4'b0010;
      runCycles(41);
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("burst_cnt_%0d", i), 256'(burst_cnt[i*32 +: 32]),
                     256'((i == 1) ? 10 : 0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule

// File: doc/wrdm_desc_arbiter.md
WRDM_DESC_ARBITER -- requirements
Module: wrdm_desc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of descriptor requesters (2..8).
REQ-002 Parameter DESC_WIDTH, default 174, write-data-mover descriptor width.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester descriptor valid.
REQ-006 req_data  input  NUM_REQ*DESC_WIDTH  flattened descriptors, requester i at bits [i*DESC_WIDTH +: DESC_WIDTH].
REQ-007 req_last  input  NUM_REQ  marks final descriptor of a requester's burst (data low/high, then done descriptor).
REQ-008 req_ready  output  NUM_REQ  per-requester accept.
REQ-009 wrdm_desc_valid  output  1  descriptor valid to write data mover.
REQ-010 wrdm_desc_data  output  DESC_WIDTH  descriptor to write data mover.
REQ-011 wrdm_desc_ready  input  1  write data mover accepts current descriptor.
REQ-012 grant_id  output  $clog2(NUM_REQ)  requester currently owning the port.
REQ-013 grant_active  output  1  high while a burst is locked.

Function
REQ-014 Handshakes: beat transfers on requester i when req_valid[i] & req_ready[i]; on output when wrdm_desc_valid & wrdm_desc_ready.
REQ-015 FSM states IDLE, LOCKED.
REQ-016 IDLE: if any req_valid, select winner round-robin starting at (last_grant+1) mod NUM_REQ; register grant_id, set grant_active, go LOCKED next cycle; req_ready all zero in IDLE.
REQ-017 LOCKED: req_ready[grant_id] = ~wrdm_desc_valid | wrdm_desc_ready; all other req_ready bits zero.
REQ-018 Accepted beat loads output register next cycle: wrdm_desc_valid=1, wrdm_desc_data=req_data of grantee; latency exactly 1 cycle.
REQ-019 Output register holds valid and data stable until wrdm_desc_ready; clears valid on ready with no new accepted beat.
REQ-020 Accepted beat with req_last=1: last_grant<=grant_id, grant_active<=0, go IDLE; no other requester's beat interleaves inside a burst.
REQ-021 Back-to-back: one beat per cycle sustained when wrdm_desc_ready held high.
REQ-022 Re-arbitration costs exactly one IDLE cycle between bursts; final output descriptor may still be pending during that cycle.
REQ-023 Grantee deasserting req_valid mid-burst: arbiter stays LOCKED, no timeout.
REQ-024 Requester with req_valid and req_last both high on first beat is a single-descriptor burst.
REQ-025 req_valid changes of non-granted requesters never affect grant_id while LOCKED.
REQ-026 Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0.

Reset
REQ-027 On rst: state IDLE, wrdm_desc_valid=0, wrdm_desc_data=0, req_ready=0, grant_id=0, grant_active=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-028 rst mid-burst discards the pending output descriptor and lock; next cycle after rst deasserts behaves as first cycle after power-up.

Configuration
REQ-029 Macro WRDM_ARB_STATS_EN: when defined, add output burst_cnt (NUM_REQ*32 bits), per-requester 32-bit wrapping count of completed bursts (incremented on accepted req_last beat), cleared by rst.
REQ-030 Without WRDM_ARB_STATS_EN, port burst_cnt and its counters are absent; all other behaviour identical.

Verification
REQ-031 After reset, req_valid=4'b1111, all bursts 3 beats, wrdm_desc_ready=1 -> output order req0 x3, req1 x3, req2 x3, req3 x3, req0...; no interleave.
REQ-032 req_valid[2] only, 1 beat last=1, data=174'h5A -> grant_id=2 next cycle, wrdm_desc_valid with data 174'h5A one cycle after accept.
REQ-033 Burst active, wrdm_desc_ready=0 for 5 cycles -> wrdm_desc_valid/data stable, req_ready[grant_id]=0; resumes on ready=1 without loss or duplication.
REQ-034 req1 locked, req0 and req3 raise valid mid-burst -> req1 completes; next grant is req3 (round-robin from 1), then req0.
REQ-035 rst asserted with wrdm_desc_valid=1 mid-burst -> next cycle all outputs at reset values; req0 granted first afterwards.
REQ-036 WRDM_ARB_STATS_EN defined, 10 bursts from req1 -> burst_cnt[1]=10, others 0; build without macro compiles and passes REQ-031..035.
